// File: rtl/pma_pkg.sv
// pma_pkg: shared defaults, lookup state encoding and window_id extraction
package pma_pkg;

    localparam int ENTRY_W_DEF = 144;
    localparam int WID_W_DEF   = 12;
    localparam int ENTRY_MAX   = 1024;
    localparam int WID_MAX     = 32;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} lk_state_e;

    // window_id sits in the top ww bits of an ew-bit entry; inputs are zero-extended to the max widths
    function automatic logic [WID_MAX-1:0] wid_of(input logic [ENTRY_MAX-1:0] e, input int ew, input int ww);
        logic [ENTRY_MAX-1:0] s;
        s = e >> (ew - ww);
        return s[WID_MAX-1:0] & ({WID_MAX{1'b1}} >> (WID_MAX - ww));
    endfunction

endpackage

// File: rtl/pma_ram_2r1w.sv
// pma_ram_2r1w: anchor array with one write port, a registered read port and a combinational scan port
module pma_ram_2r1w
    import pma_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int ENTRY_W = ENTRY_W_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we_i,
    input  logic [ADDR_W-1:0]  waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic               re_i,
    input  logic [ADDR_W-1:0]  raddr_i,
    output logic [ENTRY_W-1:0] rdata_o,
    input  logic [ADDR_W-1:0]  saddr_i,
    output logic [ENTRY_W-1:0] sdata_o
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] rdata_q;

    // array storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    // registered read sees the pre-write contents on a same-slot collision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else if (re_i) rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;
    assign sdata_o = mem[saddr_i];

endmodule

// File: rtl/pma_anchor_store.sv
// pma_anchor_store: ring-buffered anchor store with direct read and newest-first window_id lookup
module pma_anchor_store
    import pma_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int ENTRY_W = ENTRY_W_DEF,
    parameter int WID_W   = WID_W_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ENTRY_W-1:0] wr_data,
    output logic [ADDR_W-1:0]  wr_slot,
    output logic               evict,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_valid,
    input  logic               lk_valid,
    output logic               lk_ready,
    input  logic [WID_W-1:0]   lk_wid,
    output logic               lk_done,
    output logic               lk_hit,
    output logic [ADDR_W-1:0]  lk_slot,
    output logic [ENTRY_W-1:0] lk_data,
    output logic [ADDR_W:0]    count,
    output logic               full
);

    lk_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  head_q, head_d, idx_q, idx_d, wr_slot_q, wr_slot_d, lk_slot_q, lk_slot_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic               evict_q, evict_d, rd_valid_q, rd_valid_d, lk_hit_q, lk_hit_d;
    logic [ENTRY_W-1:0] lk_data_q, lk_data_d, scan_data;
    logic [WID_W-1:0]   wid_q, wid_d;
    logic [ADDR_W-1:0]  scan_addr;
    logic               wr_fire, lk_fire, scan_hit, scan_last;

    assign wr_ready  = state_q == IDLE && !clear;
    assign lk_ready  = state_q == IDLE && !clear;
    assign wr_fire   = wr_valid && wr_ready;
    assign lk_fire   = lk_valid && lk_ready;
    assign full      = count_q == (ADDR_W+1)'(DEPTH);
    assign scan_addr = head_q - ADDR_W'(1) - idx_q;
    assign scan_hit  = valid_q[scan_addr] && wid_of(ENTRY_MAX'(scan_data), ENTRY_W, WID_W) == WID_MAX'(wid_q);
    assign scan_last = count_q == '0 || {1'b0, idx_q} == count_q - 1'b1;

    pma_ram_2r1w #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_fire),
        .waddr_i (head_q),
        .wdata_i (wr_data),
        .re_i    (rd_en),
        .raddr_i (rd_addr),
        .rdata_o (rd_data),
        .saddr_i (scan_addr),
        .sdata_o (scan_data)
    );

    // ring bookkeeping, direct-read valid, and lookup FSM next state; writes stall outside IDLE so head is stable during a scan
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        count_d    = count_q;
        valid_d    = valid_q;
        idx_d      = idx_q;
        wid_d      = wid_q;
        wr_slot_d  = wr_slot_q;
        evict_d    = wr_fire && full;
        rd_valid_d = rd_en ? valid_q[rd_addr] : rd_valid_q;
        lk_hit_d   = lk_hit_q;
        lk_slot_d  = lk_slot_q;
        lk_data_d  = lk_data_q;
        if (wr_fire) begin
            valid_d[head_q] = 1'b1;
            wr_slot_d       = head_q;
            head_d          = head_q + 1'b1;
            count_d         = full ? count_q : count_q + 1'b1;
        end
        if (clear) begin
            valid_d = '0;
            head_d  = '0;
            count_d = '0;
        end
        case (state_q)
            IDLE: if (lk_fire) begin
                wid_d   = lk_wid;
                idx_d   = '0;
                state_d = SCAN;
            end
            SCAN: if (clear || (!scan_hit && scan_last)) begin
                lk_hit_d = 1'b0;
                state_d  = DONE;
            end else if (scan_hit) begin
                lk_hit_d  = 1'b1;
                lk_slot_d = scan_addr;
                lk_data_d = scan_data;
                state_d   = DONE;
            end else begin
                idx_d = idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers; async reset also aborts any scan in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            head_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            idx_q      <= '0;
            wid_q      <= '0;
            wr_slot_q  <= '0;
            evict_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            lk_hit_q   <= 1'b0;
            lk_slot_q  <= '0;
            lk_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            wid_q      <= wid_d;
            wr_slot_q  <= wr_slot_d;
            evict_q    <= evict_d;
            rd_valid_q <= rd_valid_d;
            lk_hit_q   <= lk_hit_d;
            lk_slot_q  <= lk_slot_d;
            lk_data_q  <= lk_data_d;
        end
    end

    assign wr_slot  = wr_slot_q;
    assign evict    = evict_q;
    assign rd_valid = rd_valid_q;
    assign lk_done  = state_q == DONE;
    assign lk_hit   = lk_hit_q;
    assign lk_slot  = lk_slot_q;
    assign lk_data  = lk_data_q;
    assign count    = count_q;

endmodule

// File: tb/tb_pma_anchor_store.sv
// tb_pma_anchor_store: directed checks of write, read, lookup, wrap/evict, clear and reset behaviour
module tb_pma_anchor_store;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic         clk = 0, rst = 1, clear = 0, wr_valid = 0, rd_en = 0, lk_valid = 0;
    logic [143:0] wr_data = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [11:0]  lk_wid = '0;
    logic         wr_ready, evict, rd_valid, lk_ready, lk_done, lk_hit, full;
    logic [AW-1:0] wr_slot, lk_slot;
    logic [143:0] rd_data, lk_data;
    logic [AW:0]  count;
    int errors = 0, checks = 0;

    pma_anchor_store #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clear(clear), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .wr_slot(wr_slot), .evict(evict), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_wid(lk_wid), .lk_done(lk_done), .lk_hit(lk_hit),
        .lk_slot(lk_slot), .lk_data(lk_data), .count(count), .full(full)
    );

    always #5 clk = ~clk;

    function automatic logic [143:0] mk(input logic [11:0] w, input logic [131:0] lo);
        return {w, lo};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] w, input logic [131:0] lo);
        wr_valid = 1; wr_data = mk(w, lo);
        tick;
        wr_valid = 0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        rd_en = 1; rd_addr = a;
        tick;
        rd_en = 0;
    endtask

    task automatic lookup(input logic [11:0] w, input bit with_wr, output int n, output bit stalled);
        lk_valid = 1; lk_wid = w;
        if (with_wr) begin wr_valid = 1; wr_data = mk(w, 132'(w)); end
        tick;
        lk_valid = 0; wr_valid = 0; n = 0; stalled = 1;
        while (!lk_done && n < 20) begin
            if (wr_ready !== 1'b0) stalled = 0;
            tick;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1; tick; tick; rst = 0; #1;
        checks++; if (count !== 3'd0)    begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full got %0b want 0", full); end
        checks++; if ({wr_ready, lk_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready got %b want 11", {wr_ready, lk_ready}); end
        checks++; if ({lk_done, lk_hit, evict, rd_valid} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {lk_done, lk_hit, evict, rd_valid}); end
        checks++; if (rd_data !== '0 || lk_data !== '0) begin errors++; $display("FAIL reset_data got %h/%h want 0", rd_data, lk_data); end
        checks++; if (wr_slot !== '0 || lk_slot !== '0) begin errors++; $display("FAIL reset_slots got %0d/%0d want 0", wr_slot, lk_slot); end
    endtask

    task automatic test_write_read;
        logic [143:0] e;
        e = mk(12'h042, 132'h0);
        wr(12'h042, 132'h0);
        checks++; if (wr_slot !== 2'd0) begin errors++; $display("FAIL wr_slot0 got %0d want 0", wr_slot); end
        checks++; if (count !== 3'd1)   begin errors++; $display("FAIL count1 got %0d want 1", count); end
        rd(2'd0);
        checks++; if (rd_data[143:132] !== 12'h042) begin errors++; $display("FAIL rd_wid got %h want 042", rd_data[143:132]); end
        checks++; if (rd_data !== e) begin errors++; $display("FAIL rd_data got %h want %h", rd_data, e); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL rd_valid got %b want 1", rd_valid); end
        tick;
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL rd_valid_hold got %b want 1", rd_valid); end
        rd(2'd1);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_empty got %b want 0", rd_valid); end
    endtask

    task automatic test_lookup_hit;
        int n; bit s;
        clear = 1; tick; clear = 0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL clear_count got %0d want 0", count); end
        lookup(12'h010, 0, n, s);
        checks++; if (n !== 1 || lk_hit !== 1'b0) begin errors++; $display("FAIL lk_empty got n=%0d hit=%b want n=1 hit=0", n, lk_hit); end
        tick;
        wr(12'h010, 132'h1); wr(12'h020, 132'h2); wr(12'h010, 132'h3);
        lookup(12'h010, 0, n, s);
        checks++; if (n !== 1) begin errors++; $display("FAIL lk_hit_lat got %0d want 1", n); end
        checks++; if (lk_hit !== 1'b1 || lk_slot !== 2'd2) begin errors++; $display("FAIL lk_hit_slot got hit=%b slot=%0d want 1/2", lk_hit, lk_slot); end
        checks++; if (lk_data !== mk(12'h010, 132'h3)) begin errors++; $display("FAIL lk_hit_data got %h want %h", lk_data, mk(12'h010, 132'h3)); end
        tick;
        checks++; if (lk_done !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL done_pulse got done=%b rdy=%b want 0/1", lk_done, wr_ready); end
    endtask

    task automatic test_lookup_miss;
        int n; bit s;
        lookup(12'h099, 0, n, s);
        checks++; if (n !== 3) begin errors++; $display("FAIL lk_miss_lat got %0d want 3", n); end
        checks++; if (lk_hit !== 1'b0) begin errors++; $display("FAIL lk_miss_hit got %b want 0", lk_hit); end
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL scan_stall got %b want 1", s); end
        checks++; if (lk_slot !== 2'd2) begin errors++; $display("FAIL lk_slot_hold got %0d want 2", lk_slot); end
        tick;
    endtask

    task automatic test_wrap_evict;
        int n; bit s;
        clear = 1; tick; clear = 0;
        for (int i = 1; i <= 4; i++) wr(12'(i), 132'(i));
        checks++; if (count !== 3'd4 || full !== 1'b1 || evict !== 1'b0) begin errors++; $display("FAIL fill got cnt=%0d full=%b ev=%b want 4/1/0", count, full, evict); end
        wr(12'd5, 132'd5);
        checks++; if (wr_slot !== 2'd0 || evict !== 1'b1) begin errors++; $display("FAIL evict got slot=%0d ev=%b want 0/1", wr_slot, evict); end
        checks++; if (count !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL sat got cnt=%0d full=%b want 4/1", count, full); end
        tick;
        checks++; if (evict !== 1'b0) begin errors++; $display("FAIL evict_pulse got %b want 0", evict); end
        lookup(12'd1, 0, n, s);
        checks++; if (n !== 4 || lk_hit !== 1'b0) begin errors++; $display("FAIL lk_evicted got n=%0d hit=%b want 4/0", n, lk_hit); end
        tick;
        lookup(12'd5, 0, n, s);
        checks++; if (n !== 1 || lk_hit !== 1'b1 || lk_slot !== 2'd0) begin errors++; $display("FAIL lk_wrap got n=%0d hit=%b slot=%0d want 1/1/0", n, lk_hit, lk_slot); end
        tick;
        lookup(12'd3, 0, n, s);
        checks++; if (n !== 3 || lk_slot !== 2'd2 || lk_data !== mk(12'd3, 132'd3)) begin errors++; $display("FAIL lk_order got n=%0d slot=%0d data=%h want 3/2", n, lk_slot, lk_data); end
        tick;
    endtask

    task automatic test_back_to_back;
        int n; bit s;
        rd_en = 1; rd_addr = 2'd1;
        wr(12'd6, 132'd6);
        rd_en = 0;
        checks++; if (rd_data !== mk(12'd2, 132'd2) || rd_valid !== 1'b1) begin errors++; $display("FAIL rw_collide got %h v=%b want %h v=1", rd_data, rd_valid, mk(12'd2, 132'd2)); end
        checks++; if (wr_slot !== 2'd1 || evict !== 1'b1) begin errors++; $display("FAIL rw_slot got %0d ev=%b want 1/1", wr_slot, evict); end
        rd(2'd1);
        checks++; if (rd_data !== mk(12'd6, 132'd6)) begin errors++; $display("FAIL rw_after got %h want %h", rd_data, mk(12'd6, 132'd6)); end
        lookup(12'd7, 1, n, s);
        checks++; if (n !== 1 || lk_hit !== 1'b1 || lk_slot !== 2'd2) begin errors++; $display("FAIL wr_lk_same got n=%0d hit=%b slot=%0d want 1/1/2", n, lk_hit, lk_slot); end
        checks++; if (lk_data !== mk(12'd7, 132'd7)) begin errors++; $display("FAIL wr_lk_data got %h want %h", lk_data, mk(12'd7, 132'd7)); end
        tick;
    endtask

    task automatic test_clear;
        lk_valid = 1; lk_wid = 12'h0FF;
        tick;
        lk_valid = 0;
        tick;
        clear = 1;
        tick;
        clear = 0;
        checks++; if (lk_done !== 1'b1 || lk_hit !== 1'b0) begin errors++; $display("FAIL clear_abort got done=%b hit=%b want 1/0", lk_done, lk_hit); end
        checks++; if (count !== 3'd0 || full !== 1'b0) begin errors++; $display("FAIL clear_cnt got %0d full=%b want 0/0", count, full); end
        tick;
        rd(2'd0);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL clear_rdv got %b want 0", rd_valid); end
        clear = 1; wr_valid = 1; wr_data = mk(12'h123, 132'h0);
        #1;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL clear_rdy got %b want 0", wr_ready); end
        tick;
        clear = 0; wr_valid = 0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL clear_wins got %0d want 0", count); end
    endtask

    task automatic test_rst_scan;
        bit seen;
        wr(12'h0A1, 132'h1); wr(12'h0A2, 132'h2);
        rd(2'd0);
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_rdv got %b want 1", rd_valid); end
        lk_valid = 1; lk_wid = 12'h0FF;
        tick;
        lk_valid = 0;
        #2 rst = 1;
        #1;
        seen = lk_done;
        tick;
        rst = 0;
        for (int i = 0; i < 4; i++) begin seen |= lk_done; tick; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_done got %b want 0", seen); end
        checks++; if (count !== 3'd0 || lk_ready !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL rst_state got cnt=%0d rdy=%b rdv=%b want 0/1/0", count, lk_ready, rd_valid); end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_lookup_hit;
        test_lookup_miss;
        test_wrap_evict;
        test_back_to_back;
        test_clear;
        test_rst_scan;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
